// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serialising multi-port memory arbiter.
// Size encodings map to the index of the last byte of a transfer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_IO_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    // Encoding 2'b11 is accepted and handled as a full word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_last = 2'd0;
            SZ_HALF: size_last = 2'd1;
            default: size_last = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Request masking and grant selection. Fixed priority (lowest index) by default;
// defining MEM_ARB_RR_EN selects round-robin starting after the last granted port.
module mem_arb_grant #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] done_mask,
    output logic [NUM_PORTS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_any
);

    logic [NUM_PORTS-1:0] req_eligible;

    // A port whose completion pulse is visible this cycle must not be re-granted at once.
    assign req_eligible = req_valid & ~done_mask;

`ifdef MEM_ARB_RR_EN
    logic [ID_W-1:0] ptr_reg;
    int              idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= ID_W'(NUM_PORTS - 1);
        end else if (en && grant_any) begin
            ptr_reg <= grant_id;
        end
    end

    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr_reg) + 1 + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!grant_any && req_eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, en};

    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_eligible[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
        assign grant[gi] = grant_any && (grant_id == ID_W'(gi));
    end

endmodule

// File: rtl/mem_port_arb.sv
// Multi-port controller serialising sized loads/stores onto an 8-bit RAM/IO bus,
// with abort, IO-full stalling and global freeze. MEM_ARB_RR_EN selects round-robin grant.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int         NUM_PORTS = 2,
    parameter int         ADDR_W    = 32,
    parameter logic [1:0] IO_SEL    = IO_SEL_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [7:0]                  mem_din,
    output logic [7:0]                  mem_dout,
    output logic [ADDR_W-1:0]           mem_a,
    output logic                        mem_wr,
    input  logic                        io_buffer_full,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [2*NUM_PORTS-1:0]      req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]        resp_done,
    output logic [31:0]                 resp_rdata
);

    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t                state_reg, state_next;
    logic [1:0]            cnt_reg, cnt_next;
    logic [1:0]            last_reg, last_next;
    logic [ID_W-1:0]       port_reg, port_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [31:0]           rdata_reg, rdata_next;
    logic [ADDR_W-1:0]     mem_a_reg, mem_a_next;
    logic [7:0]            mem_dout_reg, mem_dout_next;
    logic                  mem_wr_reg, mem_wr_next;
    logic [NUM_PORTS-1:0]  resp_done_reg, resp_done_next;
    logic [31:0]           resp_rdata_reg, resp_rdata_next;

    logic [NUM_PORTS-1:0]  grant;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_any;
    logic                  grant_take;

    logic [ADDR_W-1:0]     sel_addr;
    logic [31:0]           sel_wdata;
    logic [1:0]            sel_size;
    logic                  sel_wr;

    logic [1:0]            cnt_inc;
    logic [ADDR_W-1:0]     addr_inc;
    logic [ADDR_W-1:0]     addr_cur;
    logic [31:0]           rdata_cap;
    logic                  port_valid;

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[17:16] == IO_SEL;
    endfunction

    mem_arb_grant #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .en        (grant_take && rdy),
        .req_valid (req_valid),
        .done_mask (resp_done_reg),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // One-hot AND-OR selection of the granted port's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_size  = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | req_wdata[i*32 +: 32];
                sel_size  = sel_size  | req_size[i*2 +: 2];
                sel_wr    = sel_wr    | req_wr[i];
            end
        end
    end

    assign cnt_inc    = cnt_reg + 2'd1;
    assign addr_inc   = addr_reg + ADDR_W'(cnt_inc);
    assign addr_cur   = addr_reg + ADDR_W'(cnt_reg);
    assign port_valid = req_valid[port_reg];

    always_comb begin
        rdata_cap = rdata_reg;
        rdata_cap[{cnt_reg, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_next       = last_reg;
        port_next       = port_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        mem_a_next      = mem_a_reg;
        mem_dout_next   = mem_dout_reg;
        mem_wr_next     = 1'b0;
        resp_done_next  = '0;
        resp_rdata_next = resp_rdata_reg;
        grant_take      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    grant_take = 1'b1;
                    port_next  = grant_id;
                    addr_next  = sel_addr;
                    last_next  = size_last(sel_size);
                    wdata_next = sel_wdata;
                    cnt_next   = 2'd0;
                    rdata_next = '0;
                    if (!sel_wr) begin
                        mem_a_next = sel_addr;
                        state_next = ST_READ;
                    end else if (is_io(sel_addr) && io_buffer_full) begin
                        state_next = ST_IO_WAIT;
                    end else begin
                        mem_a_next    = sel_addr;
                        mem_dout_next = sel_wdata[7:0];
                        mem_wr_next   = 1'b1;
                        state_next    = ST_WRITE;
                    end
                end
            end

            ST_READ: begin
                if (!port_valid) begin
                    state_next = ST_IDLE;
                end else begin
                    rdata_next = rdata_cap;
                    if (cnt_reg == last_reg) begin
                        resp_done_next[port_reg] = 1'b1;
                        resp_rdata_next          = rdata_cap;
                        state_next               = ST_IDLE;
                    end else begin
                        mem_a_next = addr_inc;
                        cnt_next   = cnt_inc;
                    end
                end
            end

            ST_WRITE: begin
                if (!port_valid) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == last_reg) begin
                    resp_done_next[port_reg] = 1'b1;
                    state_next               = ST_IDLE;
                end else if (is_io(addr_inc) && io_buffer_full) begin
                    // cnt now names the pending byte, which IO_WAIT issues on release.
                    cnt_next   = cnt_inc;
                    state_next = ST_IO_WAIT;
                end else begin
                    mem_a_next    = addr_inc;
                    mem_dout_next = wdata_reg[{cnt_inc, 3'b000} +: 8];
                    mem_wr_next   = 1'b1;
                    cnt_next      = cnt_inc;
                end
            end

            ST_IO_WAIT: begin
                if (!port_valid) begin
                    state_next = ST_IDLE;
                end else if (!io_buffer_full) begin
                    mem_a_next    = addr_cur;
                    mem_dout_next = wdata_reg[{cnt_reg, 3'b000} +: 8];
                    mem_wr_next   = 1'b1;
                    state_next    = ST_WRITE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_reg       <= '0;
            port_reg       <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            mem_a_reg      <= '0;
            mem_dout_reg   <= '0;
            mem_wr_reg     <= 1'b0;
            resp_done_reg  <= '0;
            resp_rdata_reg <= '0;
        end else if (rdy) begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_reg       <= last_next;
            port_reg       <= port_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            mem_a_reg      <= mem_a_next;
            mem_dout_reg   <= mem_dout_next;
            mem_wr_reg     <= mem_wr_next;
            resp_done_reg  <= resp_done_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    assign mem_a      = mem_a_reg;
    assign mem_dout   = mem_dout_reg;
    assign mem_wr     = mem_wr_reg;
    assign resp_done  = resp_done_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule
